// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared definitions for the PC sequencing unit.
// Holds the branch-condition encoding, the sequencer FSM state type and
// the condition-evaluation helper used by the top.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        kCOND_ALWAYS = 2'b00,
        kCOND_EQ     = 2'b01,
        kCOND_LT     = 2'b10,
        kCOND_GT     = 2'b11
    } cond_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        HALTED = 2'b10
    } seq_state_t;

    // Evaluates a branch condition against the flags latched by the last CMP.
    function automatic logic cond_true(input cond_sel_t sel,
                                       input logic lt, input logic eq, input logic gt);
        case (sel)
            kCOND_ALWAYS: cond_true = 1'b1;
            kCOND_EQ:     cond_true = eq;
            kCOND_LT:     cond_true = lt;
            kCOND_GT:     cond_true = gt;
            default:      cond_true = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// pc_sequencer_ras_stack: return-address stack for CALL/RET.
// LIFO of RAS_DEPTH entries; the caller guarantees push only when not full
// and pop only when not empty. clear empties the stack synchronously.
module ras_stack #(
    parameter int PC_WIDTH  = 12,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                push,
    input  logic                pop,
    input  logic [PC_WIDTH-1:0] push_data,
    output logic [PC_WIDTH-1:0] top,
    output logic                empty,
    output logic                full
);
    import pc_sequencer_pkg::*;

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [PTR_W:0]        cnt;
    logic [PTR_W-1:0]      wr_idx;
    logic [PTR_W-1:0]      top_idx;
    logic [PC_WIDTH-1:0]   mem [RAS_DEPTH];

    // Depth is a power of two, so the low pointer bits index the entry array directly.
    assign wr_idx  = cnt[PTR_W-1:0];
    assign top_idx = cnt[PTR_W-1:0] - PTR_W'(1);
    assign empty   = (cnt == '0);
    assign full    = (cnt == (PTR_W+1)'(RAS_DEPTH));
    assign top     = mem[top_idx];

    // Occupancy counter: the only control state of the stack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (push) begin
            cnt <= cnt + (PTR_W+1)'(1);
        end else if (pop) begin
            cnt <= cnt - (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are meaningless while below the pointer, so no reset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter, CMP flag latch, SET_REG bank prefixes,
// start/run/halt FSM and return-address stack for the core.
// Optional build macro PC_SEQ_PERF_CNT_EN adds 32-bit cycle and retire
// counters; without it cycle_cnt/retire_cnt are constant zero.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_WIDTH  = 12,
    parameter int OFF_WIDTH = 4,
    parameter int BANK_W    = 2,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_en,
    input  logic                 cmp_en,
    input  logic                 lt_in,
    input  logic                 eq_in,
    input  logic                 gt_in,
    input  logic [1:0]           cond_sel,
    input  logic                 rel_branch_en,
    input  logic [OFF_WIDTH-1:0] rel_offset,
    input  logic                 abs_branch_en,
    input  logic [PC_WIDTH-1:0]  abs_target,
    input  logic                 call_en,
    input  logic                 ret_en,
    input  logic                 bank_set_en,
    input  logic [BANK_W-1:0]    bank_dest_in,
    input  logic [BANK_W-1:0]    bank_src_in,
    output logic [PC_WIDTH-1:0]  current_pc,
    output logic                 lt_q,
    output logic                 eq_q,
    output logic                 gt_q,
    output logic [BANK_W-1:0]    bank_dest,
    output logic [BANK_W-1:0]    bank_src,
    output logic                 busy,
    output logic                 done,
    output logic                 ras_err,
    output logic [31:0]          cycle_cnt,
    output logic [31:0]          retire_cnt
);

    localparam logic [PC_WIDTH-1:0] PC_INIT = PC_WIDTH'(RESET_PC);

    // Sign-extends a relative branch offset to the PC width.
    function automatic logic [PC_WIDTH-1:0] sign_ext(input logic signed [OFF_WIDTH-1:0] off);
        logic signed [PC_WIDTH-1:0] ext;
        ext = PC_WIDTH'(off);
        sign_ext = ext;
    endfunction

    seq_state_t           state;
    logic                 retire;
    logic                 start_ok;
    logic                 cond_ok;
    logic [PC_WIDTH-1:0]  pc_inc;
    logic [PC_WIDTH-1:0]  pc_nxt;
    logic                 ras_err_set;
    logic                 ras_push;
    logic                 ras_pop;
    logic [PC_WIDTH-1:0]  ras_top;
    logic                 ras_empty;
    logic                 ras_full;

    assign retire   = (state == RUN) && !stall;
    assign start_ok = start && (state != RUN);
    assign cond_ok  = cond_true(cond_sel_t'(cond_sel), lt_q, eq_q, gt_q);
    assign pc_inc   = current_pc + PC_WIDTH'(1);

    // Stack moves only on a retiring RET/CALL that wins priority and is legal.
    assign ras_pop  = retire && !halt_en && ret_en && !ras_empty;
    assign ras_push = retire && !halt_en && !ret_en && call_en && !ras_full;

    ras_stack #(
        .PC_WIDTH  (PC_WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (start_ok),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Next-PC selection in decode priority order: halt, ret, call, abs, rel, sequential.
    always_comb begin
        pc_nxt      = pc_inc;
        ras_err_set = 1'b0;
        if (halt_en) begin
            pc_nxt = current_pc;
        end else if (ret_en) begin
            if (ras_empty) begin
                ras_err_set = 1'b1;
            end else begin
                pc_nxt = ras_top;
            end
        end else if (call_en) begin
            pc_nxt = abs_target;
            if (ras_full) begin
                ras_err_set = 1'b1;
            end
        end else if (abs_branch_en && cond_ok) begin
            pc_nxt = abs_target;
        end else if (rel_branch_en && cond_ok) begin
            pc_nxt = current_pc + sign_ext(rel_offset);
        end
    end

    // Sequencer FSM with registered PC, flags, bank prefixes and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            current_pc <= PC_INIT;
            lt_q       <= 1'b0;
            eq_q       <= 1'b0;
            gt_q       <= 1'b0;
            bank_dest  <= '0;
            bank_src   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ras_err    <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state      <= RUN;
                        current_pc <= PC_INIT;
                        lt_q       <= 1'b0;
                        eq_q       <= 1'b0;
                        gt_q       <= 1'b0;
                        bank_dest  <= '0;
                        bank_src   <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (halt_en) begin
                            state     <= HALTED;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            lt_q      <= 1'b0;
                            eq_q      <= 1'b0;
                            gt_q      <= 1'b0;
                            bank_dest <= '0;
                            bank_src  <= '0;
                        end else begin
                            current_pc <= pc_nxt;
                            lt_q       <= cmp_en & lt_in;
                            eq_q       <= cmp_en & eq_in;
                            gt_q       <= cmp_en & gt_in;
                            bank_dest  <= bank_set_en ? bank_dest_in : '0;
                            bank_src   <= bank_set_en ? bank_src_in  : '0;
                            if (ras_err_set) begin
                                ras_err <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_SEQ_PERF_CNT_EN
    logic [31:0] cycle_q;
    logic [31:0] retire_q;

    // Free-running performance counters, restarted with each program launch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else if (start_ok) begin
            cycle_q  <= '0;
            retire_q <= '0;
        end else begin
            if (state == RUN) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (retire) begin
                retire_q <= retire_q + 32'd1;
            end
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer with
// default parameters (PC_WIDTH=12, OFF_WIDTH=4, BANK_W=2, RAS_DEPTH=4, RESET_PC=0).
module tb_pc_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stall;
    logic        halt_en;
    logic        cmp_en;
    logic        lt_in, eq_in, gt_in;
    logic [1:0]  cond_sel;
    logic        rel_branch_en;
    logic [3:0]  rel_offset;
    logic        abs_branch_en;
    logic [11:0] abs_target;
    logic        call_en;
    logic        ret_en;
    logic        bank_set_en;
    logic [1:0]  bank_dest_in, bank_src_in;
    logic [11:0] current_pc;
    logic        lt_q, eq_q, gt_q;
    logic [1:0]  bank_dest, bank_src;
    logic        busy, done, ras_err;
    logic [31:0] cycle_cnt, retire_cnt;

    int tests = 0;
    int fails = 0;

    pc_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .stall         (stall),
        .halt_en       (halt_en),
        .cmp_en        (cmp_en),
        .lt_in         (lt_in),
        .eq_in         (eq_in),
        .gt_in         (gt_in),
        .cond_sel      (cond_sel),
        .rel_branch_en (rel_branch_en),
        .rel_offset    (rel_offset),
        .abs_branch_en (abs_branch_en),
        .abs_target    (abs_target),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .bank_set_en   (bank_set_en),
        .bank_dest_in  (bank_dest_in),
        .bank_src_in   (bank_src_in),
        .current_pc    (current_pc),
        .lt_q          (lt_q),
        .eq_q          (eq_q),
        .gt_q          (gt_q),
        .bank_dest     (bank_dest),
        .bank_src      (bank_src),
        .busy          (busy),
        .done          (done),
        .ras_err       (ras_err),
        .cycle_cnt     (cycle_cnt),
        .retire_cnt    (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        start = 0; stall = 0; halt_en = 0; cmp_en = 0;
        lt_in = 0; eq_in = 0; gt_in = 0; cond_sel = 2'b00;
        rel_branch_en = 0; rel_offset = 4'h0; abs_branch_en = 0; abs_target = 12'h000;
        call_en = 0; ret_en = 0; bank_set_en = 0; bank_dest_in = 2'd0; bank_src_in = 2'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] tgt [4];
        logic [11:0] rexp [4];
        tgt  = '{12'h020, 12'h030, 12'h040, 12'h050};
        rexp = '{12'h041, 12'h031, 12'h021, 12'h006};

        clr();
        reset_n = 1'b0;
        #2;
        check("rst_pc", current_pc, 12'h000);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ras_err", ras_err, 1'b0);
        check("rst_flags", {lt_q, eq_q, gt_q}, 3'b000);
        check("rst_banks", {bank_dest, bank_src}, 4'h0);
        @(posedge clk); #1 reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_pc", current_pc, 12'h000);

        // launch and sequential fetch
        start = 1; tick(); start = 0;
        check("start_pc", current_pc, 12'h000);
        check("start_busy", busy, 1'b1);
        check("start_done", done, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("seq_pc", current_pc, 32'(i));
        end
        repeat (4) tick();
        check("seq_pc9", current_pc, 12'h009);

        // CMP eq then relative branch -3 at pc 10
        cmp_en = 1; eq_in = 1; tick(); clr();
        check("cmp_pc", current_pc, 12'h00A);
        check("cmp_eq", {lt_q, eq_q, gt_q}, 3'b010);
        rel_branch_en = 1; cond_sel = 2'b01; rel_offset = 4'hD; tick(); clr();
        check("rel_taken_pc", current_pc, 12'h007);
        check("rel_flags_clr", eq_q, 1'b0);
        cmp_en = 1; eq_in = 1; tick(); clr();
        tick();
        check("nonbr_clears_eq", eq_q, 1'b0);
        rel_branch_en = 1; cond_sel = 2'b01; rel_offset = 4'hD; tick(); clr();
        check("rel_fallthru_pc", current_pc, 12'h00A);

        // call / ret
        abs_branch_en = 1; abs_target = 12'h004; tick(); clr();
        check("abs_pc", current_pc, 12'h004);
        call_en = 1; abs_target = 12'h020; tick(); clr();
        check("call_pc", current_pc, 12'h020);
        ret_en = 1; tick(); clr();
        check("ret_pc", current_pc, 12'h005);
        check("ret_no_err", ras_err, 1'b0);

        // nested calls overflow the 4-entry stack
        for (int k = 0; k < 4; k++) begin
            call_en = 1; abs_target = tgt[k]; tick(); clr();
            check("nest_call_pc", current_pc, tgt[k]);
        end
        check("nest4_no_err", ras_err, 1'b0);
        call_en = 1; abs_target = 12'h060; tick(); clr();
        check("call5_pc", current_pc, 12'h060);
        check("call5_err", ras_err, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ret_en = 1; tick(); clr();
            check("nest_ret_pc", current_pc, rexp[k]);
        end

        // start in RUN is ignored
        start = 1; tick(); clr();
        check("start_in_run_pc", current_pc, 12'h007);
        check("start_in_run_busy", busy, 1'b1);

        // wrap and relative edge cases
        abs_branch_en = 1; abs_target = 12'hFFF; tick(); clr();
        check("abs_fff", current_pc, 12'hFFF);
        tick();
        check("wrap_pc", current_pc, 12'h000);
        rel_branch_en = 1; rel_offset = 4'hF; tick(); clr();
        check("rel_neg_wrap", current_pc, 12'hFFF);
        abs_branch_en = 1; abs_target = 12'h000; tick(); clr();
        rel_branch_en = 1; rel_offset = 4'h0; tick(); clr();
        check("rel_zero", current_pc, 12'h000);
        abs_branch_en = 1; cond_sel = 2'b10; abs_target = 12'h055; tick(); clr();
        check("abs_lt_not_taken", current_pc, 12'h001);

        // reset clears sticky error; ret on empty stack
        reset_n = 1'b0; #2;
        check("rst2_ras_err", ras_err, 1'b0);
        @(posedge clk); #1 reset_n = 1'b1;
        start = 1; tick(); clr();
        check("restart_pc", current_pc, 12'h000);
        ret_en = 1; tick(); clr();
        check("ret_empty_pc", current_pc, 12'h001);
        check("ret_empty_err", ras_err, 1'b1);

        // stall freezes everything
        cmp_en = 1; gt_in = 1; bank_set_en = 1; bank_dest_in = 2'd1; bank_src_in = 2'd2;
        tick(); clr();
        check("pre_stall_pc", current_pc, 12'h002);
        check("pre_stall_gt", {lt_q, eq_q, gt_q}, 3'b001);
        check("pre_stall_banks", {bank_dest, bank_src}, 4'b0110);
        stall = 1; rel_branch_en = 1; cond_sel = 2'b11; rel_offset = 4'h5;
        cmp_en = 1; lt_in = 1; bank_set_en = 1; bank_dest_in = 2'd3; bank_src_in = 2'd3;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_pc", current_pc, 12'h002);
            check("stall_flags", {lt_q, eq_q, gt_q}, 3'b001);
            check("stall_banks", {bank_dest, bank_src}, 4'b0110);
        end
        stall = 0; cmp_en = 0; lt_in = 0; bank_set_en = 0;
        tick(); clr();
        check("unstall_pc", current_pc, 12'h007);
        check("unstall_flags", {lt_q, eq_q, gt_q}, 3'b000);
        check("unstall_banks", {bank_dest, bank_src}, 4'h0);

        // SET_REG prefix lasts one retire
        bank_set_en = 1; bank_dest_in = 2'd2; bank_src_in = 2'd3; tick(); clr();
        check("setreg_dest", bank_dest, 2'd2);
        check("setreg_src", bank_src, 2'd3);
        tick();
        check("setreg_clr", {bank_dest, bank_src}, 4'h0);
        check("pre_halt_pc", current_pc, 12'h009);

        // halt and relaunch
        halt_en = 1; tick(); clr();
        check("halt_done", done, 1'b1);
        check("halt_busy", busy, 1'b0);
        check("halt_pc", current_pc, 12'h009);
        tick();
        check("halt_hold_pc", current_pc, 12'h009);
        start = 1; tick(); clr();
        check("relaunch_pc", current_pc, 12'h000);
        check("relaunch_done", done, 1'b0);
        check("relaunch_busy", busy, 1'b1);
        check("relaunch_err_kept", ras_err, 1'b1);

        // performance counters
        tick(); tick();
        stall = 1; tick(); clr();
`ifdef PC_SEQ_PERF_CNT_EN
        check("perf_cycles", cycle_cnt, 32'd3);
        check("perf_retires", retire_cnt, 32'd2);
`else
        check("perf_cycles_off", cycle_cnt, 32'd0);
        check("perf_retires_off", retire_cnt, 32'd0);
`endif

        // asynchronous reset mid-run
        cmp_en = 1; lt_in = 1; bank_set_en = 1; bank_dest_in = 2'd3; bank_src_in = 2'd3;
        tick(); clr();
        check("prerst_pc", current_pc, 12'h003);
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_pc", current_pc, 12'h000);
        check("async_rst_flags", {lt_q, eq_q, gt_q}, 3'b000);
        check("async_rst_banks", {bank_dest, bank_src}, 4'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_err", ras_err, 1'b0);
        check("async_rst_cnt", cycle_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
